// File: rtl/calendar_gregorian.sv
// calendar_gregorian
//   Successor calendar in the clk_50MHz domain. Advances day/month/year on
//   end_of_day with full Gregorian leap rules, applies debounced manual
//   increments (with day clamping) and a validated parallel load, and
//   drives registered BCD digits for the display mux.
//
//   Optional feature macro: CALENDAR_DOW_EN (builds the day-of-week register).
//
// Ports:
//   clk_50MHz   system clock
//   reset       asynchronous, active-low reset
//   end_of_day  one-cycle advance pulse from the binary clock
//   btn_day/btn_month/btn_year  raw asynchronous buttons, active-high
//   load, load_year/month/day/dow   parallel load strobe and value
//   load_err    one-cycle pulse when a load is rejected
//   new_year    one-cycle pulse on Dec 31 -> Jan 1 rollover
//   leap        current year is a leap year (combinational)
//   m_bcd, d_bcd, y_bcd  registered BCD date digits
//   dow         day of week (0=Mon..6=Sun), constant 0 without the feature
module calendar_gregorian #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_YEAR      = 2024,
    parameter int RESET_MONTH     = 1,
    parameter int RESET_DAY       = 1,
    parameter int RESET_DOW       = 0
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        end_of_day,
    input  logic        btn_day,
    input  logic        btn_month,
    input  logic        btn_year,
    input  logic        load,
    input  logic [13:0] load_year,
    input  logic [3:0]  load_month,
    input  logic [4:0]  load_day,
    input  logic [2:0]  load_dow,
    output logic        load_err,
    output logic        new_year,
    output logic        leap,
    output logic [7:0]  m_bcd,
    output logic [7:0]  d_bcd,
    output logic [15:0] y_bcd,
    output logic [2:0]  dow
);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic f_leap(input logic [13:0] y);
        return (y[1:0] == 2'd0) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [4:0] f_mlen(input logic [3:0] m, input logic lp);
        logic [4:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = lp ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

    // Repeated subtraction keeps the converter free of wide dividers.
    function automatic logic [15:0] f_bcd4(input logic [13:0] v);
        logic [13:0] r;
        logic [3:0]  th, hu, te;
        r  = v;
        th = 4'd0;
        hu = 4'd0;
        te = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (r >= 14'd1000) begin r = r - 14'd1000; th = th + 4'd1; end
        end
        for (int k = 0; k < 9; k++) begin
            if (r >= 14'd100) begin r = r - 14'd100; hu = hu + 4'd1; end
        end
        for (int k = 0; k < 9; k++) begin
            if (r >= 14'd10) begin r = r - 14'd10; te = te + 4'd1; end
        end
        return {th, hu, te, r[3:0]};
    endfunction

    function automatic logic [7:0] f_bcd2(input logic [4:0] v);
        logic [4:0] r;
        logic [3:0] te;
        r  = v;
        te = 4'd0;
        for (int k = 0; k < 3; k++) begin
            if (r >= 5'd10) begin r = r - 5'd10; te = te + 4'd1; end
        end
        return {te, r[3:0]};
    endfunction

    localparam logic [13:0] LP_RESET_YEAR  = 14'(RESET_YEAR);
    localparam logic [3:0]  LP_RESET_MONTH = 4'(RESET_MONTH);
    localparam logic [4:0]  LP_RESET_DAY   = 5'(RESET_DAY);
    localparam logic [2:0]  LP_RESET_DOW   = 3'(RESET_DOW);
    localparam logic [15:0] LP_Y_BCD = f_bcd4(LP_RESET_YEAR);
    localparam logic [7:0]  LP_M_BCD = f_bcd2({1'b0, LP_RESET_MONTH});
    localparam logic [7:0]  LP_D_BCD = f_bcd2(LP_RESET_DAY);
    localparam int          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning: 2-FF sync, stability counter, rising-edge pulse
    // ------------------------------------------------------------------
    logic [2:0] w_btn_raw;
    logic [2:0] w_inc;     // [0]=day, [1]=month, [2]=year

    assign w_btn_raw = {btn_year, btn_month, btn_day};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic             r_level_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    // Any sample matching the accepted level restarts the count,
                    // so only an unbroken run of differing samples is accepted.
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LP_CNT_MAX) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_inc[gi] = r_level & ~r_level_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Date state and next-state logic
    // ------------------------------------------------------------------
    logic [13:0] r_year,  w_year_next;
    logic [3:0]  r_month, w_month_next;
    logic [4:0]  r_day,   w_day_next;
    logic        r_new_year, w_new_year_next;
    logic        r_load_err, w_load_err_next;
    logic [15:0] r_y_bcd;
    logic [7:0]  r_m_bcd, r_d_bcd;

    logic [4:0]  w_cur_len;
    logic [3:0]  w_month_inc;
    logic [4:0]  w_month_inc_len;
    logic [13:0] w_year_inc;
    logic        w_load_ok;

    assign leap            = f_leap(r_year);
    assign w_cur_len       = f_mlen(r_month, leap);
    assign w_month_inc     = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
    assign w_month_inc_len = f_mlen(w_month_inc, leap);
    assign w_year_inc      = (r_year == 14'd9999) ? 14'd0 : r_year + 14'd1;

`ifdef CALENDAR_DOW_EN
    logic [2:0] r_dow, w_dow_next, w_dow_inc;
    assign w_dow_inc = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
    assign w_load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_year <= 14'd9999) && (load_day >= 5'd1) &&
                       (load_day <= f_mlen(load_month, f_leap(load_year))) &&
                       (load_dow <= 3'd6);
`else
    assign w_load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_year <= 14'd9999) && (load_day >= 5'd1) &&
                       (load_day <= f_mlen(load_month, f_leap(load_year)));
`endif

    // Only the highest-priority event in a cycle is applied; a rejected
    // load still owns the cycle, so nothing else changes the date then.
    always_comb begin
        w_year_next     = r_year;
        w_month_next    = r_month;
        w_day_next      = r_day;
        w_new_year_next = 1'b0;
        w_load_err_next = 1'b0;
`ifdef CALENDAR_DOW_EN
        w_dow_next      = r_dow;
`endif
        if (load) begin
            if (w_load_ok) begin
                w_year_next  = load_year;
                w_month_next = load_month;
                w_day_next   = load_day;
`ifdef CALENDAR_DOW_EN
                w_dow_next   = load_dow;
`endif
            end else begin
                w_load_err_next = 1'b1;
            end
        end else if (end_of_day) begin
            if (r_day == w_cur_len) begin
                w_day_next = 5'd1;
                if (r_month == 4'd12) begin
                    w_month_next    = 4'd1;
                    w_year_next     = w_year_inc;
                    w_new_year_next = 1'b1;
                end else begin
                    w_month_next = r_month + 4'd1;
                end
            end else begin
                w_day_next = r_day + 5'd1;
            end
`ifdef CALENDAR_DOW_EN
            w_dow_next = w_dow_inc;
`endif
        end else if (w_inc[0]) begin
            w_day_next = (r_day == w_cur_len) ? 5'd1 : r_day + 5'd1;
`ifdef CALENDAR_DOW_EN
            w_dow_next = w_dow_inc;
`endif
        end else if (w_inc[1]) begin
            w_month_next = w_month_inc;
            if (r_day > w_month_inc_len) begin
                w_day_next = w_month_inc_len;
            end
        end else if (w_inc[2]) begin
            w_year_next = w_year_inc;
            if ((r_month == 4'd2) && (r_day == 5'd29) && !f_leap(w_year_inc)) begin
                w_day_next = 5'd28;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_year     <= LP_RESET_YEAR;
            r_month    <= LP_RESET_MONTH;
            r_day      <= LP_RESET_DAY;
            r_new_year <= 1'b0;
            r_load_err <= 1'b0;
            r_y_bcd    <= LP_Y_BCD;
            r_m_bcd    <= LP_M_BCD;
            r_d_bcd    <= LP_D_BCD;
        end else begin
            r_year     <= w_year_next;
            r_month    <= w_month_next;
            r_day      <= w_day_next;
            r_new_year <= w_new_year_next;
            r_load_err <= w_load_err_next;
            // Digits follow the binary registers one cycle later.
            r_y_bcd    <= f_bcd4(r_year);
            r_m_bcd    <= f_bcd2({1'b0, r_month});
            r_d_bcd    <= f_bcd2(r_day);
        end
    end

`ifdef CALENDAR_DOW_EN
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_dow <= LP_RESET_DOW;
        end else begin
            r_dow <= w_dow_next;
        end
    end
    assign dow = r_dow;
`else
    logic w_unused_dow;
    assign w_unused_dow = ^{load_dow, LP_RESET_DOW};
    assign dow          = 3'd0;
`endif

    assign new_year = r_new_year;
    assign load_err = r_load_err;
    assign y_bcd    = r_y_bcd;
    assign m_bcd    = r_m_bcd;
    assign d_bcd    = r_d_bcd;

endmodule

// File: tb/tb_calendar_gregorian.sv
// Directed bench for calendar_gregorian with a cycle-stamped scoreboard:
// stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_calendar_gregorian;

    logic        clk_50MHz = 1'b0;
    logic        reset = 1'b0;
    logic        end_of_day = 1'b0;
    logic        btn_day = 1'b0, btn_month = 1'b0, btn_year = 1'b0;
    logic        load = 1'b0;
    logic [13:0] load_year = '0;
    logic [3:0]  load_month = '0;
    logic [4:0]  load_day = '0;
    logic [2:0]  load_dow = '0;
    logic        load_err, new_year, leap;
    logic [7:0]  m_bcd, d_bcd;
    logic [15:0] y_bcd;
    logic [2:0]  dow;

`ifdef CALENDAR_DOW_EN
    localparam bit DOW_ON = 1'b1;
`else
    localparam bit DOW_ON = 1'b0;
`endif

    calendar_gregorian #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .end_of_day(end_of_day),
        .btn_day   (btn_day),
        .btn_month (btn_month),
        .btn_year  (btn_year),
        .load      (load),
        .load_year (load_year),
        .load_month(load_month),
        .load_day  (load_day),
        .load_dow  (load_dow),
        .load_err  (load_err),
        .new_year  (new_year),
        .leap      (leap),
        .m_bcd     (m_bcd),
        .d_bcd     (d_bcd),
        .y_bcd     (y_bcd),
        .dow       (dow)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Observation: {dow, leap, new_year, load_err, m_bcd, d_bcd, y_bcd}
    typedef struct {
        int          at;
        string       name;
        logic [37:0] exp;
        logic [37:0] mask;
    } entry_t;

    localparam logic [37:0] FULL_MASK  = {38{1'b1}};
    localparam logic [37:0] PULSE_MASK = {3'b000, 3'b111, 32'd0};

    entry_t sb_q[$];
    entry_t mon_e;
    logic [37:0] obs;
    int checks = 0;
    int failures = 0;

    always @(negedge clk_50MHz) begin
        obs = {dow, leap, new_year, load_err, m_bcd, d_bcd, y_bcd};
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ((obs & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                failures++;
                $display("FAIL %s: got %h required %h (mask %h) cyc=%0d",
                         mon_e.name, obs & mon_e.mask, mon_e.exp & mon_e.mask, mon_e.mask, cyc);
            end else begin
                $display("ok   %s: %h cyc=%0d", mon_e.name, obs & mon_e.mask, cyc);
            end
        end
    end

    task automatic push(input int at, input string nm, input logic [37:0] exp, input logic [37:0] mask);
        entry_t e;
        e.at = at; e.name = nm; e.exp = exp; e.mask = mask;
        sb_q.push_back(e);
    endtask

    // Full date check one cycle from now (called at a negedge).
    task automatic check_date(input string nm, input logic [15:0] ey, input logic [7:0] em,
                              input logic [7:0] ed, input logic el, input logic [2:0] ew);
        push(cyc + 1, nm, {(DOW_ON ? ew : 3'd0), el, 1'b0, 1'b0, em, ed, ey}, FULL_MASK);
        @(negedge clk_50MHz);
    endtask

    // One load/end_of_day transaction: pulses checked on the event cycle,
    // BCD digits one cycle later.
    task automatic step(input string nm, input logic do_ld, input logic [13:0] ly,
                        input logic [3:0] lm, input logic [4:0] ldd, input logic [2:0] lw,
                        input logic do_eod, input logic [15:0] ey, input logic [7:0] em,
                        input logic [7:0] ed, input logic el, input logic [2:0] ew,
                        input logic eny, input logic eerr);
        load = do_ld; load_year = ly; load_month = lm; load_day = ldd; load_dow = lw;
        end_of_day = do_eod;
        push(cyc + 1, {nm, "_pulse"}, {3'd0, el, eny, eerr, 32'd0}, PULSE_MASK);
        push(cyc + 2, nm, {(DOW_ON ? ew : 3'd0), el, 1'b0, 1'b0, em, ed, ey}, FULL_MASK);
        @(negedge clk_50MHz);
        load = 1'b0; end_of_day = 1'b0;
        @(negedge clk_50MHz);
    endtask

    task automatic press(input int which, input int hold);
        case (which)
            0: btn_day = 1'b1;
            1: btn_month = 1'b1;
            default: btn_year = 1'b1;
        endcase
        repeat (hold) @(negedge clk_50MHz);
        btn_day = 1'b0; btn_month = 1'b0; btn_year = 1'b0;
        repeat (hold) @(negedge clk_50MHz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low: reset date visible straight away.
        @(negedge clk_50MHz);
        check_date("reset", 16'h2024, 8'h01, 8'h01, 1'b1, 3'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        check_date("after_reset_idle", 16'h2024, 8'h01, 8'h01, 1'b1, 3'd0);

        step("ld_2024_02_28", 1, 14'd2024, 4'd2, 5'd28, 3'd0, 0, 16'h2024, 8'h02, 8'h28, 1, 3'd0, 0, 0);
        step("eod_to_feb29",  0, 14'd0, 4'd0, 5'd0, 3'd0, 1, 16'h2024, 8'h02, 8'h29, 1, 3'd1, 0, 0);
        step("ld_2100_02_28", 1, 14'd2100, 4'd2, 5'd28, 3'd2, 0, 16'h2100, 8'h02, 8'h28, 0, 3'd2, 0, 0);
        step("eod_2100_mar1", 0, 14'd0, 4'd0, 5'd0, 3'd0, 1, 16'h2100, 8'h03, 8'h01, 0, 3'd3, 0, 0);
        step("ld_2000_02_28", 1, 14'd2000, 4'd2, 5'd28, 3'd5, 0, 16'h2000, 8'h02, 8'h28, 1, 3'd5, 0, 0);
        step("eod_2000_feb29",0, 14'd0, 4'd0, 5'd0, 3'd0, 1, 16'h2000, 8'h02, 8'h29, 1, 3'd6, 0, 0);
        step("ld_9999_12_31", 1, 14'd9999, 4'd12, 5'd31, 3'd6, 0, 16'h9999, 8'h12, 8'h31, 0, 3'd6, 0, 0);
        step("eod_year_wrap", 0, 14'd0, 4'd0, 5'd0, 3'd0, 1, 16'h0000, 8'h01, 8'h01, 1, 3'd0, 1, 0);

        step("ld_2024_03_31", 1, 14'd2024, 4'd3, 5'd31, 3'd3, 0, 16'h2024, 8'h03, 8'h31, 1, 3'd3, 0, 0);
        press(1, 20);
        check_date("btn_month_clamp", 16'h2024, 8'h04, 8'h30, 1'b1, 3'd3);
        repeat (10) begin
            btn_day = 1'b1; repeat (2) @(negedge clk_50MHz);
            btn_day = 1'b0; repeat (2) @(negedge clk_50MHz);
        end
        repeat (10) @(negedge clk_50MHz);
        check_date("btn_day_bounce", 16'h2024, 8'h04, 8'h30, 1'b1, 3'd3);
        press(0, 20);
        check_date("btn_day_wrap", 16'h2024, 8'h04, 8'h01, 1'b1, 3'd4);

        step("ld_2023_02_29_rej", 1, 14'd2023, 4'd2, 5'd29, 3'd0, 0, 16'h2024, 8'h04, 8'h01, 1, 3'd4, 0, 1);
        step("ld_wins_over_eod",  1, 14'd2024, 4'd12, 5'd31, 3'd1, 1, 16'h2024, 8'h12, 8'h31, 1, 3'd1, 0, 0);
        step("eod_new_year",      0, 14'd0, 4'd0, 5'd0, 3'd0, 1, 16'h2025, 8'h01, 8'h01, 0, 3'd2, 1, 0);

        step("ld_2024_02_29", 1, 14'd2024, 4'd2, 5'd29, 3'd0, 0, 16'h2024, 8'h02, 8'h29, 1, 3'd0, 0, 0);
        press(2, 20);
        check_date("btn_year_clamp", 16'h2025, 8'h02, 8'h28, 1'b0, 3'd0);

        step("ld_month13_rej", 1, 14'd2025, 4'd13, 5'd1, 3'd0, 0, 16'h2025, 8'h02, 8'h28, 0, 3'd0, 0, 1);
        step("ld_day0_rej",    1, 14'd2025, 4'd3, 5'd0, 3'd0, 0, 16'h2025, 8'h02, 8'h28, 0, 3'd0, 0, 1);
        step("ld_year10000_rej", 1, 14'd10000, 4'd3, 5'd1, 3'd0, 0, 16'h2025, 8'h02, 8'h28, 0, 3'd0, 0, 1);
        step("ld_dow7", 1, 14'd2025, 4'd2, 5'd28, 3'd7, 0, 16'h2025, 8'h02, 8'h28, 0, 3'd0, 0, DOW_ON);

        step("ld_2024_01_01", 1, 14'd2024, 4'd1, 5'd1, 3'd0, 0, 16'h2024, 8'h01, 8'h01, 1, 3'd0, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            step($sformatf("eod_jan%0d", k), 0, 14'd0, 4'd0, 5'd0, 3'd0, 1,
                 16'h2024, 8'h01, 8'(k), 1, 3'((k - 1) % 7), 0, 0);
        end

        // Mid-operation reset returns straight to the reset date, no pulses after.
        reset = 1'b0;
        check_date("mid_reset", 16'h2024, 8'h01, 8'h01, 1'b1, 3'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        check_date("post_reset_quiet", 16'h2024, 8'h01, 8'h01, 1'b1, 3'd0);

        repeat (4) @(negedge clk_50MHz);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
